// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// 2*WIDTH-bit product presented on P_hi:P_lo with a start/busy/done handshake.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P_hi,
  output logic [WIDTH-1:0] P_lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] p_hi_q,  p_hi_d;
  logic [WIDTH-1:0] p_lo_q,  p_lo_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d = A;
          p_hi_d  = '0;
          p_lo_d  = B;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Right shift of {carry, P_hi, P_lo}: the add carry lands in P_hi's MSB.
        {p_hi_d, p_lo_d} = {sum, p_lo_q[WIDTH-1:1]};
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign P_hi = p_hi_q;
  assign P_lo = p_lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised bench for seq_multiplier (WIDTH=32); products are checked
// against plain 64-bit arithmetic, timing against the handshake rules.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] P_hi;
  logic [W-1:0] P_lo;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          last_z;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P_hi  (P_hi),
    .P_lo  (P_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or DONE. mode 0: quiet inputs
  // during RUN; 1: random start/A/B noise; 2: start held, A=2/B=4.
  // chain=1 leaves the DUT in its DONE cycle for a back-to-back start.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int mode, input bit chain);
    logic [63:0] exp;
    int          lat;
    int          nbusy;
    exp   = 64'(a) * 64'(b);
    lat   = 0;
    nbusy = 0;
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
      if (mode == 1) begin
        start = 1'($urandom);
        A     = $urandom;
        B     = $urandom;
      end else if (mode == 2) begin
        start = 1'b1;
        A     = 2;
        B     = 4;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'd33);
    check("busy_cycles", 64'(nbusy), 64'd32);
    check("product", {P_hi, P_lo}, exp);
    check("busy_in_done", 64'(busy), 64'd0);
    last_z = done && (P_lo == '0);
    if (!chain) begin
      @(negedge clk);
      check("done_single_pulse", 64'(done), 64'd0);
      check("product_hold", {P_hi, P_lo}, exp);
    end
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", {P_hi, P_lo}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    mult(32'd3, 32'd5, 0, 0);
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("max_hi", 64'(P_hi), 64'hFFFF_FFFE);
    mult(32'h0001_0000, 32'h0001_0000, 0, 0);
    check("zero_flag_qualified", 64'(last_z), 64'd1);
    check("zero_flag_unqualified", 64'(done && (P_lo == '0)), 64'd0);
    mult(32'd0, 32'hDEAD_BEEF, 0, 0);

    mult(32'd7, 32'd9, 2, 1);
    mult(32'd2, 32'd4, 0, 0);

    // Abort mid-RUN with an asynchronous reset away from any clock edge.
    start = 1'b1;
    A     = 32'h1234_5678;
    B     = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_prod", {P_hi, P_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("no_resume", 64'(dones), 64'd0);
    mult(32'd6, 32'd7, 0, 0);

    for (int t = 0; t < 1000; t++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      mult($urandom, $urandom, (t % 2 == 0) ? 1 : 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
